// File: rtl/ids_window_sequencer.sv
// IDS chi-square front-end: routes samples to population/window stores,
// paces statistic calculations and tracks verdict, overrun and timeout.
module ids_window_sequencer #(
  parameter int POPSIZE      = 100,
  parameter int WINSIZE      = 200,
  parameter int FRAME_SIZE   = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int CALC_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_rdy,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  samp_valid,
  output logic [DATA_WIDTH-1:0] samp_data,
  output logic [ADDR_WIDTH-1:0] samp_addr,
  output logic                  samp_is_pop,
  output logic                  calc_start,
  input  logic                  calc_done,
  input  logic                  calc_exceed,
  output logic                  is_attacked,
  output logic [1:0]            phase,
  output logic                  calc_busy,
  output logic                  frame_overrun,
  output logic                  calc_timeout
);

  localparam logic [1:0] POP_FILL  = 2'd0;
  localparam logic [1:0] WIN_PRIME = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam int FW = $clog2(FRAME_SIZE + 1);
  localparam int TW = $clog2(CALC_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pop_cnt, win_ptr;
  logic [FW-1:0]         frame_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic                  req_q, req_d;
  logic                  pop_last, win_last, frame_last;
  logic                  done_ok, tmo_hit, busy_free;

  assign pop_last   = pop_cnt == ADDR_WIDTH'(POPSIZE - 1);
  assign win_last   = win_ptr == ADDR_WIDTH'(WINSIZE - 1);
  assign frame_last = frame_cnt == FW'(FRAME_SIZE - 1);

  // A finishing or expiring calculation frees the slot for a same-edge request
  assign done_ok   = calc_done && calc_busy;
  assign tmo_hit   = calc_busy && !calc_done && (tmo_cnt == '0);
  assign busy_free = !calc_busy || done_ok || tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= POP_FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    if (data_rdy) begin
      case (state_q)
        POP_FILL:  if (pop_last) state_d = WIN_PRIME;
        WIN_PRIME: if (win_last) begin
          state_d = RUN;
          req_d   = 1'b1;
        end
        RUN:       req_d = frame_last;
        default:   state_d = POP_FILL;
      endcase
    end
  end

  always_comb begin
    phase = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pop_cnt     <= '0;
      win_ptr     <= '0;
      frame_cnt   <= '0;
      req_q       <= 1'b0;
      samp_valid  <= 1'b0;
      samp_data   <= '0;
      samp_addr   <= '0;
      samp_is_pop <= 1'b0;
    end else begin
      req_q      <= req_d;
      samp_valid <= data_rdy;
      if (data_rdy) begin
        samp_data   <= data_in;
        samp_is_pop <= state_q == POP_FILL;
        if (state_q == POP_FILL) begin
          samp_addr <= pop_cnt;
          pop_cnt   <= pop_cnt + 1'b1;
        end else begin
          samp_addr <= win_ptr;
          win_ptr   <= win_last ? '0 : win_ptr + 1'b1;
          if (state_q == RUN)
            frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      calc_start    <= 1'b0;
      calc_busy     <= 1'b0;
      tmo_cnt       <= '0;
      is_attacked   <= 1'b0;
      frame_overrun <= 1'b0;
      calc_timeout  <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      if (done_ok) is_attacked <= calc_exceed;
      if (tmo_hit) calc_timeout <= 1'b1;
      if (req_q && busy_free) begin
        calc_start <= 1'b1;
        calc_busy  <= 1'b1;
        tmo_cnt    <= TW'(CALC_TIMEOUT - 1);
      end else begin
        if (req_q) frame_overrun <= 1'b1;
        if (done_ok || tmo_hit) calc_busy <= 1'b0;
        else if (calc_busy)     tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ids_window_sequencer.sv
// Randomized bench for ids_window_sequencer against a sample-count and
// deadline based reference model.
module tb_ids_window_sequencer;

  localparam int POPSIZE      = 100;
  localparam int WINSIZE      = 200;
  localparam int FRAME_SIZE   = 20;
  localparam int CALC_TIMEOUT = 255;
  localparam int NCYC         = 24000;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_rdy;
  logic [7:0] data_in;
  logic       samp_valid;
  logic [7:0] samp_data;
  logic [7:0] samp_addr;
  logic       samp_is_pop;
  logic       calc_start;
  logic       calc_done;
  logic       calc_exceed;
  logic       is_attacked;
  logic [1:0] phase;
  logic       calc_busy;
  logic       frame_overrun;
  logic       calc_timeout;

  ids_window_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .data_rdy     (data_rdy),
    .data_in      (data_in),
    .samp_valid   (samp_valid),
    .samp_data    (samp_data),
    .samp_addr    (samp_addr),
    .samp_is_pop  (samp_is_pop),
    .calc_start   (calc_start),
    .calc_done    (calc_done),
    .calc_exceed  (calc_exceed),
    .is_attacked  (is_attacked),
    .phase        (phase),
    .calc_busy    (calc_busy),
    .frame_overrun(frame_overrun),
    .calc_timeout (calc_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int ecnt = 0;
  int nsamp = 0;
  int deadline = 0;
  bit m_busy, m_req, just_rst;
  int e_valid, e_data, e_addr, e_pop, e_start;
  int e_att, e_phase, e_over, e_tmo;
  int starts_exp = 0;
  int starts_got = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, ecnt, got, exp);
    end
  endtask

  task automatic model_step();
    bit req_now;
    ecnt++;
    e_start = 0;
    if (!rst) begin
      nsamp = 0; m_busy = 0; m_req = 0; just_rst = 1;
      e_valid = 0; e_data = 0; e_addr = 0; e_pop = 0;
      e_att = 0; e_phase = 0; e_over = 0; e_tmo = 0;
    end else begin
      just_rst = 0;
      req_now = m_req;
      m_req = 0;
      e_valid = data_rdy;
      if (data_rdy) begin
        e_pop  = nsamp < POPSIZE;
        e_addr = e_pop ? nsamp : (nsamp - POPSIZE) % WINSIZE;
        e_data = data_in;
        nsamp++;
        m_req = nsamp >= POPSIZE + WINSIZE &&
                (nsamp - POPSIZE - WINSIZE) % FRAME_SIZE == 0;
      end
      e_phase = nsamp < POPSIZE ? 0 :
                nsamp < POPSIZE + WINSIZE ? 1 : 2;
      if (calc_done && m_busy) begin
        e_att = calc_exceed;
        m_busy = 0;
      end
      if (m_busy && ecnt == deadline) begin
        e_tmo = 1;
        m_busy = 0;
      end
      if (req_now) begin
        if (!m_busy) begin
          e_start = 1;
          m_busy = 1;
          deadline = ecnt + CALC_TIMEOUT;
          starts_exp++;
        end else begin
          e_over = 1;
        end
      end
    end
  endtask

  task automatic compare();
    check("samp_valid", samp_valid, e_valid);
    if (e_valid || just_rst) begin
      check("samp_data", samp_data, e_data);
      check("samp_addr", samp_addr, e_addr);
      check("samp_is_pop", samp_is_pop, e_pop);
    end
    check("calc_start", calc_start, e_start);
    check("calc_busy", calc_busy, m_busy);
    check("is_attacked", is_attacked, e_att);
    check("phase", phase, e_phase);
    check("frame_overrun", frame_overrun, e_over);
    check("calc_timeout", calc_timeout, e_tmo);
    if (calc_start) starts_got++;
  endtask

  initial begin
    rst = 1'b0;
    data_rdy = 1'b0;
    data_in = '0;
    calc_done = 1'b0;
    calc_exceed = 1'b0;
    model_step();
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      compare();
      rst         = !(i < 2 || $urandom_range(0, 3999) == 0);
      data_rdy    = $urandom_range(0, 2) == 0;
      data_in     = 8'($urandom);
      calc_done   = $urandom_range(0, 99) == 0;
      calc_exceed = 1'($urandom);
      model_step();
    end
    @(negedge clk);
    compare();
    check("start_count", starts_got, starts_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
